// File: rtl/prbs8_checker.sv
// prbs8_checker: receive-side checker for the 8-bit PRBS generator
// (x^8+x^6+x^5+x^4+1, Fibonacci, left shift, feedback into LSB).
// Self-synchronises to the serial stream, then checks it against a
// free-running reference. Reports lock, per-bit error pulses and
// saturating error / checked-bit counts.
//
// Optional build macro PRBS8_CHK_STICKY_LOSS_EN adds o_lock_lost, a sticky
// flag set whenever lock is lost, cleared by i_clear (set wins) or reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SEARCH | shifting in 8 received bits to seed the predictor
// ST_VERIFY | predicting each bit from the last 8; counting good runs
// ST_LOCKED | checking against a free-running reference, counting errors

module prbs8_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
`ifdef PRBS8_CHK_STICKY_LOSS_EN
    ,
    output logic             o_lock_lost
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_CNT_C    = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_ERRS_C = 8'(UNLOCK_ERRS);

    function automatic logic fb(input logic [7:0] x);
        return x[7] ^ x[5] ^ x[4] ^ x[3];
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [7:0]       ref_q, ref_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       errrun_q, errrun_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lost_q, lost_d;

    logic [7:0]       sr_shift;
    logic             pred_bit;
    logic             exp_bit;
    logic             err_inc;
    logic             bit_inc;
    logic             lost_set;

    assign sr_shift = {sr_q[6:0], i_bit};
    assign pred_bit = fb(sr_q);
    assign exp_bit  = fb(ref_q);

    // Next-state and next-output computation for one sampled bit.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        ref_d     = ref_q;
        fill_d    = fill_q;
        match_d   = match_q;
        errrun_d  = errrun_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        err_inc   = 1'b0;
        bit_inc   = 1'b0;
        lost_set  = 1'b0;

        if (i_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    sr_d = sr_shift;
                    if (fill_q == 3'd7) begin
                        fill_d  = 3'd0;
                        state_d = ST_VERIFY;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                ST_VERIFY: begin
                    sr_d = sr_shift;
                    // An all-zero window would predict zeros forever, so it never counts.
                    if ((i_bit == pred_bit) && (sr_q != 8'd0)) begin
                        match_d = match_q + 8'd1;
                        if (match_d == LOCK_CNT_C) begin
                            state_d  = ST_LOCKED;
                            ref_d    = sr_shift;
                            match_d  = 8'd0;
                            errrun_d = 8'd0;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Reference never loads i_bit: one flipped bit gives exactly one error.
                    ref_d   = {ref_q[6:0], exp_bit};
                    bit_inc = 1'b1;
                    if (i_bit != exp_bit) begin
                        err_d    = 1'b1;
                        err_inc  = 1'b1;
                        errrun_d = errrun_q + 8'd1;
                        if (errrun_d == UNLOCK_ERRS_C) begin
                            state_d  = ST_SEARCH;
                            fill_d   = 3'd0;
                            match_d  = 8'd0;
                            errrun_d = 8'd0;
                            locked_d = 1'b0;
                            lost_set = 1'b1;
                        end
                    end else begin
                        errrun_d = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (i_clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            if (err_inc && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (bit_inc && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        lost_d = lost_q;
        if (i_clear) lost_d = 1'b0;
        if (lost_set) lost_d = 1'b1;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            sr_q      <= 8'd0;
            ref_q     <= 8'd0;
            fill_q    <= 3'd0;
            match_q   <= 8'd0;
            errrun_q  <= 8'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            ref_q     <= ref_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            errrun_q  <= errrun_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            lost_q    <= lost_d;
        end
    end

    assign o_locked  = locked_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_bit_cnt = bit_cnt_q;

`ifdef PRBS8_CHK_STICKY_LOSS_EN
    assign o_lock_lost = lost_q;
`else
    logic unused_lost;
    assign unused_lost = lost_q;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: a 16-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream; both are compared every cycle against
// a history-based model of the stream recurrence b[n]=b[n-8]^b[n-6]^b[n-5]^b[n-4].
module tb_prbs8_checker;
    localparam int LOCK_CNT    = 16;
    localparam int UNLOCK_ERRS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_bit = 1'b0;
    logic i_clear = 1'b0;

    logic        o_locked, o_err, o_locked4, o_err4;
    logic [15:0] o_err_cnt, o_bit_cnt;
    logic [3:0]  ec4, bc4;
`ifdef PRBS8_CHK_STICKY_LOSS_EN
    logic o_lock_lost, lost4;
`endif

    always #5 clk = ~clk;

    prbs8_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_bit(i_bit), .i_clear(i_clear),
        .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt), .o_bit_cnt(o_bit_cnt)
`ifdef PRBS8_CHK_STICKY_LOSS_EN
        , .o_lock_lost(o_lock_lost)
`endif
    );

    prbs8_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_bit(i_bit), .i_clear(i_clear),
        .o_locked(o_locked4), .o_err(o_err4), .o_err_cnt(ec4), .o_bit_cnt(bc4)
`ifdef PRBS8_CHK_STICKY_LOSS_EN
        , .o_lock_lost(lost4)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: 0 search, 1 verify, 2 locked.
    int mode, mcnt, mrun, m_errs, m_bits;
    bit rx[$];
    bit rq[$];
    bit m_err, m_lost;

    logic [7:0] g;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        mode = 0; mcnt = 0; mrun = 0; m_errs = 0; m_bits = 0;
        rx.delete(); rq.delete();
        m_err = 1'b0; m_lost = 1'b0;
    endtask

    task automatic model_update(input bit v, input bit b, input bit c);
        bit lost_set, nz, pred, e;
        lost_set = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (mode == 0) begin
                rx.push_back(b);
                if (rx.size() > 8) void'(rx.pop_front());
                mcnt++;
                if (mcnt == 8) begin mode = 1; mcnt = 0; end
            end else if (mode == 1) begin
                nz = 1'b0;
                foreach (rx[i]) if (rx[i]) nz = 1'b1;
                pred = rx[$-7] ^ rx[$-5] ^ rx[$-4] ^ rx[$-3];
                rx.push_back(b);
                if (rx.size() > 8) void'(rx.pop_front());
                if (b == pred && nz) mcnt++; else mcnt = 0;
                if (mcnt == LOCK_CNT) begin mode = 2; rq = rx; mrun = 0; mcnt = 0; end
            end else begin
                e = rq[$-7] ^ rq[$-5] ^ rq[$-4] ^ rq[$-3];
                rq.push_back(e);
                void'(rq.pop_front());
                m_bits++;
                if (b != e) begin
                    m_err = 1'b1;
                    m_errs++;
                    mrun++;
                    if (mrun == UNLOCK_ERRS) begin
                        mode = 0; mcnt = 0; mrun = 0; lost_set = 1'b1;
                    end
                end else begin
                    mrun = 0;
                end
            end
        end
        if (c) begin m_errs = 0; m_bits = 0; m_lost = 1'b0; end
        if (lost_set) m_lost = 1'b1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("locked", o_locked, mode == 2);
            chk("err", o_err, m_err);
            chk("err_cnt", o_err_cnt, sat(m_errs, 16));
            chk("bit_cnt", o_bit_cnt, sat(m_bits, 16));
            chk("locked4", o_locked4, mode == 2);
            chk("err_cnt4", ec4, sat(m_errs, 4));
            chk("bit_cnt4", bc4, sat(m_bits, 4));
`ifdef PRBS8_CHK_STICKY_LOSS_EN
            chk("lock_lost", o_lock_lost, m_lost);
            chk("lock_lost4", lost4, m_lost);
`endif
        end
    end

    task automatic step(input bit v, input bit b, input bit c);
        @(negedge clk);
        i_valid = v; i_bit = b; i_clear = c;
        @(posedge clk);
        #1;
        model_update(v, b, c);
    endtask

    task automatic gen_bit(output bit nb);
        nb = g[7] ^ g[5] ^ g[4] ^ g[3];
        g  = {g[6:0], nb};
    endtask

    task automatic send_gen(input bit flip, input bit clr);
        bit nb;
        gen_bit(nb);
        step(1'b1, nb ^ flip, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0; i_bit = 1'b0; i_clear = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_locked", o_locked, 0);
        chk("rst_err", o_err, 0);
        chk("rst_err_cnt", o_err_cnt, 0);
        chk("rst_bit_cnt", o_bit_cnt, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        g = 8'h01;
    endtask

    initial begin
        int n;
        bit v, fl, cl;
        model_reset();
        g = 8'h01;
        #12;
        do_reset();
        chk_en = 1'b1;

        // Clean stream from seed 0x01: lock after exactly 24 valid bits.
        for (int i = 0; i < 23; i++) send_gen(1'b0, 1'b0);
        chk("lock_pre24", o_locked, 0);
        send_gen(1'b0, 1'b0);
        chk("lock_at24", o_locked, 1);
        for (int i = 0; i < 1000; i++) send_gen(1'b0, 1'b0);
        chk("clean_err_cnt", o_err_cnt, 0);
        chk("clean_bit_cnt", o_bit_cnt, 1000);

        // Single inverted bit.
        send_gen(1'b1, 1'b0);
        chk("single_err_pulse", o_err, 1);
        send_gen(1'b0, 1'b0);
        chk("single_err_end", o_err, 0);
        chk("single_err_cnt", o_err_cnt, 1);
        chk("single_locked", o_locked, 1);

        // Clear on a clean valid bit, then four consecutive errors force unlock.
        send_gen(1'b0, 1'b1);
        chk("clear_err_cnt", o_err_cnt, 0);
        chk("clear_bit_cnt", o_bit_cnt, 0);
        for (int i = 0; i < 3; i++) send_gen(1'b1, 1'b0);
        chk("burst3_locked", o_locked, 1);
        send_gen(1'b1, 1'b0);
        chk("burst4_unlocked", o_locked, 0);
        chk("burst4_err_cnt", o_err_cnt, 4);
`ifdef PRBS8_CHK_STICKY_LOSS_EN
        chk("lost_set", o_lock_lost, 1);
`endif
        n = 0;
        while (!o_locked && n < 60) begin
            send_gen(1'b0, 1'b0);
            n++;
        end
        chk("relock_bits", n, 24);
`ifdef PRBS8_CHK_STICKY_LOSS_EN
        chk("lost_held_relock", o_lock_lost, 1);
        send_gen(1'b0, 1'b1);
        chk("lost_cleared", o_lock_lost, 0);
`endif

        // Error every other bit: no unlock, 4-bit counter saturates.
        send_gen(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) send_gen((i % 2) == 0, 1'b0);
        chk("sat_err_cnt4", ec4, 15);
        chk("sat_err_cnt16", o_err_cnt, 20);
        chk("sat_bit_cnt4", bc4, 15);
        chk("sat_locked", o_locked, 1);
        send_gen(1'b1, 1'b1);
        chk("clr_vs_err_cnt", o_err_cnt, 0);
        chk("clr_vs_err_cnt4", ec4, 0);
        chk("clr_vs_err_pulse", o_err, 1);

        // All-zero stream never locks.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        chk("zero_locked", o_locked, 0);
        chk("zero_err_cnt", o_err_cnt, 0);
        chk("zero_bit_cnt", o_bit_cnt, 0);

        // Random idle gaps on a clean stream.
        do_reset();
        for (int i = 0; i < 124; i++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            send_gen(1'b0, 1'b0);
            if (i == 22) chk("gap_lock_pre24", o_locked, 0);
            if (i == 23) chk("gap_lock_at24", o_locked, 1);
        end
        chk("gap_err_cnt", o_err_cnt, 0);
        chk("gap_bit_cnt", o_bit_cnt, 100);
        do_reset();

        // Randomised traffic: gaps, flips, clears.
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            cl = ($urandom_range(0, 59) == 0);
            if (v) send_gen(fl, cl);
            else   step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Receive-side partner of the 8-bit PRBS generator (polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, left shift, feedback into LSB).
- Takes the generator's serial bit stream (the newly inserted LSB each step), self-synchronises to it, and then runs a free-running reference.
- Reports lock status, per-bit errors, a saturating error count and a saturating checked-bit count.
- Used in loopback and link bring-up tests alongside the generator.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions in VERIFY required to declare lock (1..255).
- UNLOCK_ERRS, 4: consecutive errors in LOCKED that force a return to SEARCH (1..255).
- CNT_W, 16: width of o_err_cnt and o_bit_cnt.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  i_bit is valid this cycle
- i_bit  in  1  received PRBS bit
- i_clear  in  1  synchronous clear of counters (and of the sticky flag, if the optional feature is enabled)
- o_locked  out  1  checker is in LOCKED
- o_err  out  1  one-cycle pulse: the bit just checked in LOCKED mismatched
- o_err_cnt  out  CNT_W  saturating error count
- o_bit_cnt  out  CNT_W  saturating count of bits checked in LOCKED

Behaviour:
- Reset: clk is the clock; reset rst_n is asynchronous, active-low. On reset: state=SEARCH, sr=0, ref=0, fill=0, match=0, errrun=0, o_locked=0, o_err=0, o_err_cnt=0, o_bit_cnt=0.
- Feedback function: fb(x) = x[7]^x[5]^x[4]^x[3].
- Registered outputs: all outputs are registers updated on the edge that samples i_valid=1, and are visible the following cycle. Nothing changes while i_valid=0, except o_err, which returns to 0.
- SEARCH:
  - Each valid bit: sr <= {sr[6:0], i_bit}; fill++.
  - On the 8th valid bit: fill resets and state goes to VERIFY.
- VERIFY:
  - Each valid bit: pred = fb(sr). The bit is a match iff i_bit==pred and sr!=0; an all-zero sr is always a mismatch, to reject an all-zero stream.
  - Then sr <= {sr[6:0], i_bit}.
  - Match: match++. Mismatch: match=0, stay in VERIFY.
  - When match reaches LOCK_CNT on this edge: state=LOCKED, ref <= the updated sr, o_locked=1 from the next cycle.
  - No errors and no counting happen in SEARCH or VERIFY.
- LOCKED:
  - Each valid bit: exp = fb(ref); ref <= {ref[6:0], exp}. The reference is free-running and never loads i_bit, so one flipped bit gives exactly one error.
  - o_bit_cnt++ (saturating at all-ones).
  - Mismatch: o_err=1 for one cycle; o_err_cnt++ (saturating); errrun++.
  - Match: errrun=0.
  - When errrun reaches UNLOCK_ERRS: state=SEARCH, fill=0, match=0, errrun=0, o_locked=0 next cycle. The error that triggers unlock is still counted.
- Saturation: both counters hold at 2^CNT_W-1 and never wrap.
- i_clear:
  - Zeroes o_err_cnt and o_bit_cnt; this has priority over an increment in the same cycle, so that bit is not counted.
  - Does not affect the state machine, sr or ref; a valid bit in the same cycle is still processed for lock/reference.
- i_valid gaps: any number of idle cycles between bits is allowed; state is frozen during them.
- Reset mid-operation: immediate return to the reset values listed above.

Optional Feature:
- Macro: PRBS8_CHK_STICKY_LOSS_EN.
- Defined:
  - Adds output port o_lock_lost (1 bit, reset 0).
  - Set on the edge where LOCKED to SEARCH occurs; held until i_clear or reset.
  - If set and clear coincide, set wins.
- Undefined: port absent; loss of lock is visible only through o_locked.

Test Plan:
- Generator from reset (seed 0x01, stream starts 0,0,0,1,...), continuous valid, defaults -> o_locked rises the cycle after the 24th valid bit; o_err_cnt=0 and o_bit_cnt=1000 after 1000 further bits.
- After lock, invert a single bit -> exactly one o_err pulse; o_err_cnt=1; lock is held.
- After lock, invert 4 consecutive bits -> o_err_cnt=4; o_locked falls the cycle after the 4th. Resume the clean stream -> relock after 8+16 valid bits.
- Constant 0 stream for 100 bits -> o_locked stays 0; counters stay 0.
- CNT_W=4, locked, inject an error every other bit (with UNLOCK_ERRS=4) -> o_err_cnt saturates at 15, no wrap. Assert i_clear together with an erroring valid bit -> o_err_cnt=0 next cycle.
- Random i_valid gaps (0-5 idle cycles) on a clean stream -> lock is achieved with zero errors. Pulse rst_n low mid-LOCKED -> all outputs 0 immediately. Under PRBS8_CHK_STICKY_LOSS_EN, a forced unlock sets o_lock_lost, which stays 1 through relock until i_clear.
